demux_1_8_tdm: RTL and testbench
================================

DEMUX_1_8_TDM -- requirements
Module: demux_1_8_tdm

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 CLK  input  1  Rising-edge system clock.
REQ-003 RST  input  1  Asynchronous, active-high reset.
REQ-004 DIN  input  1  Serial TDM data bit. Slot k carries output bit Y[k] (slot 0 = select 000, slot 7 = select 111).
REQ-005 EN  input  1  Bit strobe. DIN and SYNC are sampled only on edges where EN=1.
REQ-006 SYNC  input  1  Frame marker. High together with EN on the slot-0 bit.
REQ-007 Y  output  8  Last completed frame, held between frames.
REQ-008 FRAME_VALID  output  1  One-cycle pulse: Y has just been updated.
REQ-009 SLOT  output  3  Slot index expected for the next strobed bit.
REQ-010 LOCK  output  1  1 while in the LOCKED state.
REQ-011 SYNC_ERR  output  1  One-cycle pulse on a framing violation.

Function
REQ-012 The block SHALL have two states: HUNT and LOCKED. LOCK SHALL equal (state==LOCKED).
REQ-013 On an edge with EN=0, the block SHALL hold all state, SLOT, and Y; FRAME_VALID and SYNC_ERR SHALL be 0 on the next cycle.
REQ-014 In HUNT with EN=1 and SYNC=0, the block SHALL discard DIN and remain in HUNT with SLOT=0.
REQ-015 In HUNT with EN=1 and SYNC=1, the block SHALL store DIN in shadow bit 0, set SLOT=1, and enter LOCKED.
REQ-016 In LOCKED with EN=1, SLOT=k in 1..6 and SYNC=0, the block SHALL store DIN in shadow bit k and set SLOT=k+1.
REQ-017 In LOCKED with EN=1, SLOT=7 and SYNC=0, on that same edge the block SHALL:
- load Y <= {DIN, shadow[6:0]};
- set SLOT=0;
- assert FRAME_VALID for exactly the following cycle.
REQ-018 Latency SHALL be 0 cycles from the slot-7 sampling edge to the Y update; FRAME_VALID SHALL be high in the cycle after that edge.
REQ-019 In LOCKED with EN=1, SLOT=0 and SYNC=1, the block SHALL treat the bit as the normal frame start, identical to REQ-015, and stay LOCKED.
REQ-020 In LOCKED with EN=1, SLOT=0 and SYNC=0, the block SHALL:
- pulse SYNC_ERR;
- discard DIN;
- enter HUNT with SLOT=0.
REQ-021 In LOCKED with EN=1, SYNC=1 and SLOT≠0, the block SHALL:
- pulse SYNC_ERR;
- abandon the partial frame, leaving Y unchanged and no FRAME_VALID;
- restart as slot 0 (store DIN in shadow bit 0, SLOT=1, stay LOCKED).
REQ-022 The SLOT counter SHALL wrap 7 -> 0 only via REQ-017; it SHALL never take any other value sequence.
REQ-023 Y SHALL change only on a frame completion (REQ-017) or on reset.

Reset
REQ-024 Assertion of RST SHALL immediately force:
- state=HUNT;
- SLOT=0, Y=8'h00, shadow=8'h00;
- FRAME_VALID=0, SYNC_ERR=0, LOCK=0.
REQ-025 A reset in the middle of a frame SHALL discard the partial frame; after release, the first strobed bit with SYNC=1 SHALL start a new frame.

Structure
REQ-026 The shared package demux_pkg SHALL hold:
- the state encoding (HUNT=0, LOCKED=1);
- FRAME_W=8;
- SLOT_W=3;
- LAST_SLOT=7.
REQ-027 The slot counter SHALL be a sub-module named tdm_slot_cnt, with inputs CLK, RST, inc, clr, load1 and output SLOT. All other logic SHALL reside in demux_1_8_tdm.

Verification
REQ-028 Reset release, then 8 strobed bits 1,0,1,0,0,1,0,1 with SYNC on the first -> Y=8'hA5, FRAME_VALID high 1 cycle, LOCK=1, SLOT=0.
REQ-029 Two back-to-back frames 8'hA5 then 8'h3C, with EN gaps of 0–3 idle cycles between bits -> Y=8'hA5 then 8'h3C, exactly two FRAME_VALID pulses, Y stable during the gaps.
REQ-030 After frame 8'hA5, a SYNC at slot 4 followed by 8 bits forming 8'hFF -> one SYNC_ERR pulse, Y stays 8'hA5 until completion, then Y=8'hFF.
REQ-031 After frame 8'hA5, slot-0 bit with SYNC=0 -> SYNC_ERR pulse, LOCK=0, SLOT=0; 7 further bits without SYNC leave Y=8'hA5 and produce no FRAME_VALID.
REQ-032 RST asserted asynchronously mid-frame at SLOT=5 -> Y=8'h00, LOCK=0, SLOT=0 with no clock edge; a following frame 8'h81 -> Y=8'h81.

Source files
------------

// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : demux_pkg
//  Purpose  : Shared types and constants for the 1:8 TDM demultiplexer.
//             Holds the framer state encoding and the frame/slot geometry.
//  Revision : 1.0  initial release
// ============================================================================
package demux_pkg;

   // Framer states: searching for a frame marker, or tracking frames.
   typedef enum logic [0:0] {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   localparam int FRAME_W   = 8;
   localparam int SLOT_W    = 3;
   localparam int LAST_SLOT = 7;

endpackage : demux_pkg
`default_nettype wire

// File: rtl/tdm_slot_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_slot_cnt
//  Purpose  : Slot index counter for the TDM demultiplexer.
//  Ports    : clk   - rising-edge clock
//             rst   - asynchronous active-high reset (slot -> 0)
//             inc   - advance slot by one
//             clr   - force slot to 0 (highest priority)
//             load1 - force slot to 1 (frame start consumed slot 0)
//             slot  - slot index expected for the next strobed bit
//  Revision : 1.0  initial release
// ============================================================================
module tdm_slot_cnt
   import demux_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              inc,
   input  logic              clr,
   input  logic              load1,
   output logic [SLOT_W-1:0] slot
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot <= '0;
      end else if (clr) begin
         slot <= '0;
      end else if (load1) begin
         slot <= SLOT_W'(1);
      end else if (inc) begin
         slot <= slot + 1'b1;
      end
   end

endmodule : tdm_slot_cnt
`default_nettype wire

// File: rtl/demux_1_8_tdm.sv
`default_nettype none
// ============================================================================
//  Module   : demux_1_8_tdm
//  Purpose  : Serial-to-parallel 1:8 TDM demultiplexer with frame alignment.
//             Slot k of each frame carries y[k]; sync marks slot 0.
//  Ports    : clk         - rising-edge clock
//             rst         - asynchronous active-high reset
//             din         - serial TDM data bit
//             en          - bit strobe, din/sync sampled only when high
//             sync        - frame marker, high on the slot-0 bit
//             y           - last completed frame
//             frame_valid - one-cycle pulse after y updates
//             slot        - slot index expected for the next strobed bit
//             lock        - high while locked to the frame
//             sync_err    - one-cycle pulse on a framing violation
//  Revision : 1.0  initial release
// ============================================================================
module demux_1_8_tdm
   import demux_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               din,
   input  logic               en,
   input  logic               sync,
   output logic [FRAME_W-1:0] y,
   output logic               frame_valid,
   output logic [SLOT_W-1:0]  slot,
   output logic               lock,
   output logic               sync_err
);

   state_t state;
   state_t state_nxt;

   // Bit 7 is never buffered: the last slot bit goes straight into y.
   logic [FRAME_W-2:0] shadow;

   logic inc;
   logic clr;
   logic load1;
   logic shadow_we;
   logic y_load;
   logic err_set;

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= HUNT;
      end else begin
         state <= state_nxt;
      end
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      state_nxt = state;
      if (en) begin
         if (sync) begin
            state_nxt = LOCKED;
         end else if (state == LOCKED && slot == '0) begin
            state_nxt = HUNT;
         end
      end
   end

   // ------------------------------------------------------- output decode
   always_comb begin
      lock      = (state == LOCKED);
      inc       = 1'b0;
      clr       = 1'b0;
      load1     = 1'b0;
      shadow_we = 1'b0;
      y_load    = 1'b0;
      err_set   = 1'b0;
      if (en) begin
         if (sync) begin
            // Frame start; a marker mid-frame abandons the partial frame.
            load1     = 1'b1;
            shadow_we = 1'b1;
            err_set   = (state == LOCKED) && (slot != '0);
         end else if (state == HUNT) begin
            clr = 1'b1;
         end else if (slot == '0) begin
            // Expected a marker but none came: lose lock.
            clr     = 1'b1;
            err_set = 1'b1;
         end else if (slot == SLOT_W'(LAST_SLOT)) begin
            clr    = 1'b1;
            y_load = 1'b1;
         end else begin
            inc       = 1'b1;
            shadow_we = 1'b1;
         end
      end
   end

   // ------------------------------------------------------- datapath regs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow      <= '0;
         y           <= '0;
         frame_valid <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         frame_valid <= y_load;
         sync_err    <= err_set;
         if (y_load) begin
            y <= {din, shadow};
         end
         // load1 always targets slot 0 regardless of the current count.
         for (int i = 0; i < FRAME_W - 1; i++) begin
            if (shadow_we && ((load1 && i == 0) || (!load1 && slot == SLOT_W'(i)))) begin
               shadow[i] <= din;
            end
         end
      end
   end

   tdm_slot_cnt u_slot_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc),
      .clr   (clr),
      .load1 (load1),
      .slot  (slot)
   );

endmodule : demux_1_8_tdm
`default_nettype wire

// File: tb/tb_demux_1_8_tdm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demux_1_8_tdm
//  Purpose  : Self-checking bench for demux_1_8_tdm.
//  Revision : 1.0  initial release
// ============================================================================
module tb_demux_1_8_tdm;

   logic       clk;
   logic       rst;
   logic       din;
   logic       en;
   logic       sync;
   logic [7:0] y;
   logic       frame_valid;
   logic [2:0] slot;
   logic       lock;
   logic       sync_err;

   int n_checks;
   int n_fail;
   int fv_count;
   int err_count;

   // Reference model state, expressed directly in frame terms.
   bit        m_locked;
   int        m_pos;
   bit        m_bits [8];
   bit [7:0]  m_y;
   bit        m_fv;
   bit        m_err;

   demux_1_8_tdm dut (
      .clk         (clk),
      .rst         (rst),
      .din         (din),
      .en          (en),
      .sync        (sync),
      .y           (y),
      .frame_valid (frame_valid),
      .slot        (slot),
      .lock        (lock),
      .sync_err    (sync_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_locked = 0;
      m_pos    = 0;
      m_y      = '0;
      m_fv     = 0;
      m_err    = 0;
      for (int i = 0; i < 8; i++) m_bits[i] = 0;
   endtask

   task automatic model_step(input bit e, input bit s, input bit d);
      m_fv  = 0;
      m_err = 0;
      if (e) begin
         if (s) begin
            if (m_locked && m_pos != 0) m_err = 1;
            m_bits[0] = d;
            m_pos     = 1;
            m_locked  = 1;
         end else if (!m_locked) begin
            m_pos = 0;
         end else if (m_pos == 0) begin
            m_err    = 1;
            m_locked = 0;
         end else begin
            m_bits[m_pos] = d;
            if (m_pos == 7) begin
               for (int i = 0; i < 8; i++) m_y[i] = m_bits[i];
               m_fv  = 1;
               m_pos = 0;
            end else begin
               m_pos++;
            end
         end
      end
   endtask

   task automatic compare_all();
      check("y",           {24'd0, y},            {24'd0, m_y});
      check("frame_valid", {31'd0, frame_valid},  {31'd0, m_fv});
      check("slot",        {29'd0, slot},         32'(m_pos));
      check("lock",        {31'd0, lock},         {31'd0, m_locked});
      check("sync_err",    {31'd0, sync_err},     {31'd0, m_err});
      if (frame_valid) fv_count++;
      if (sync_err)    err_count++;
   endtask

   // One clock: drive, let the edge happen, then compare away from it.
   task automatic step(input bit e, input bit s, input bit d);
      en   = e;
      sync = s;
      din  = d;
      @(posedge clk);
      model_step(e, s, d);
      @(negedge clk);
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0);
   endtask

   // Send bits of v for slots [first, 8) with sync on slot `first` if asked.
   task automatic send_bits(input bit [7:0] v, input int first, input bit with_sync, input int gap_mode);
      for (int k = first; k < 8; k++) begin
         step(1, with_sync && (k == first), v[k]);
         if (gap_mode != 0) idle((k + gap_mode) % 4);
      end
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      en   = 1'b0;
      sync = 1'b0;
      din  = 1'b0;
      model_reset();
      @(negedge clk);
      compare_all();
      rst = 1'b0;
      idle(1);
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      fv_count  = 0;
      err_count = 0;
      rst = 1'b1;
      en = 1'b0; sync = 1'b0; din = 1'b0;
      model_reset();

      // Reset state, pinned with literals.
      @(negedge clk);
      check("rst_y",    {24'd0, y},     32'h00);
      check("rst_lock", {31'd0, lock},  32'd0);
      check("rst_slot", {29'd0, slot},  32'd0);
      compare_all();
      rst = 1'b0;

      // Bits with no marker while hunting are discarded.
      step(1, 0, 1);
      step(1, 0, 1);
      check("hunt_lock", {31'd0, lock}, 32'd0);

      // Single frame A5.
      send_bits(8'hA5, 0, 1, 0);
      check("f1_y",    {24'd0, y},            32'hA5);
      check("f1_fv",   {31'd0, frame_valid},  32'd1);
      check("f1_lock", {31'd0, lock},         32'd1);
      check("f1_slot", {29'd0, slot},         32'd0);
      step(0, 0, 0);
      check("f1_fv_pulse", {31'd0, frame_valid}, 32'd0);

      // Back-to-back A5 then 3C with 0..3 idle gaps between bits.
      do_reset();
      fv_count = 0;
      send_bits(8'hA5, 0, 1, 1);
      check("gap_y1", {24'd0, y}, 32'hA5);
      send_bits(8'h3C, 0, 1, 2);
      check("gap_y2", {24'd0, y}, 32'h3C);
      check("gap_fv_cnt", 32'(fv_count), 32'd2);

      // Marker arrives at slot 4 -> one error, restart, then frame FF.
      do_reset();
      send_bits(8'hA5, 0, 1, 0);
      err_count = 0;
      for (int k = 0; k < 4; k++) step(1, k == 0, 1'b0);
      check("mid_slot", {29'd0, slot}, 32'd4);
      send_bits(8'hFF, 0, 1, 3);
      check("mid_err_cnt", 32'(err_count), 32'd1);
      check("mid_y", {24'd0, y}, 32'hFF);

      // Missing marker at slot 0 -> lose lock, subsequent bits ignored.
      do_reset();
      send_bits(8'hA5, 0, 1, 0);
      fv_count = 0;
      step(1, 0, 1);
      check("miss_err",  {31'd0, sync_err}, 32'd1);
      check("miss_lock", {31'd0, lock},     32'd0);
      check("miss_slot", {29'd0, slot},     32'd0);
      for (int k = 0; k < 7; k++) step(1, 0, 1);
      check("miss_y",  {24'd0, y}, 32'hA5);
      check("miss_fv", 32'(fv_count), 32'd0);

      // Asynchronous reset mid-frame at slot 5, checked before any edge.
      send_bits(8'hA5, 0, 1, 0);
      for (int k = 0; k < 5; k++) step(1, k == 0, 1'b1);
      check("pre_rst_slot", {29'd0, slot}, 32'd5);
      #2;
      rst = 1'b1;
      #1;
      check("arst_y",    {24'd0, y},    32'h00);
      check("arst_lock", {31'd0, lock}, 32'd0);
      check("arst_slot", {29'd0, slot}, 32'd0);
      model_reset();
      #1;
      rst = 1'b0;
      @(negedge clk);
      compare_all();
      send_bits(8'h81, 0, 1, 1);
      check("post_rst_y", {24'd0, y}, 32'h81);

      idle(3);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_demux_1_8_tdm
`default_nettype wire
